// File: rtl/decompressor_stream_parser_pkg.sv
// decompressor_stream_parser_pkg: shared parser states, item widths, flag values and literal packing
package decompressor_stream_parser_pkg;
  typedef enum logic [2:0] {S_CW, S_B0, S_B1, S_PRESENT, S_GAP, S_DONE, S_ERR} parser_state_t;
  localparam int CW_BITS_DEFAULT = 8;
  localparam int ITEM_WIDTH = 16;
  localparam logic LIT_FLAG = 1'b0;
  localparam logic COPY_FLAG = 1'b1;
  function automatic logic [ITEM_WIDTH-1:0] make_literal(input logic [7:0] b);
    return {8'h00, b};
  endfunction
endpackage

// File: rtl/decompressor_stream_parser.sv
// decompressor_stream_parser: unpacks an LZRW1 byte stream into 16-bit items plus a copy/literal flag
//   in:  clock, reset (async high), in_byte/in_valid/in_last, decompressor_busy
//   out: in_ready, data_in/control_word_in/data_in_valid, stream_done, format_error, items_sent
module decompressor_stream_parser
  import decompressor_stream_parser_pkg::*;
#(
  parameter int CW_BITS = CW_BITS_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ITEM_WIDTH-1:0] data_in,
  output logic                  control_word_in,
  output logic                  data_in_valid,
  input  logic                  decompressor_busy,
  output logic                  stream_done,
  output logic                  format_error,
  output logic [CNT_WIDTH-1:0]  items_sent
);
  localparam int IW = (CW_BITS > 1) ? $clog2(CW_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CW_BITS - 1);
  parser_state_t state_q;
  logic [7:0] cw_q, hi_q;
  logic [IW-1:0] idx_q;
  logic last_q, ready_q, valid_q, done_q, err_q, ctl_q;
  logic [ITEM_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic is_copy;
  // control word is consumed MSB-first
  assign is_copy = cw_q[LAST_IDX - idx_q];
  assign cnt_d = cnt_q + CNT_WIDTH'(1);
  assign in_ready = ready_q;
  assign data_in = data_q;
  assign control_word_in = ctl_q;
  assign data_in_valid = valid_q;
  assign stream_done = done_q;
  assign format_error = err_q;
  assign items_sent = cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_CW;
      cw_q    <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ctl_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        // in_ready is held low through reset, so it is raised one cycle after release
        S_CW: if (!ready_q) ready_q <= 1'b1;
        else if (in_valid) begin
          cw_q  <= in_byte;
          idx_q <= '0;
          if (in_last) begin
            state_q <= S_DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end else state_q <= S_B0;
        end
        S_B0: if (in_valid) begin
          last_q <= in_last;
          if (is_copy) begin
            hi_q <= in_byte;
            if (in_last) begin
              state_q <= S_ERR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else state_q <= S_B1;
          end else begin
            data_q  <= make_literal(in_byte);
            ctl_q   <= LIT_FLAG;
            state_q <= S_PRESENT;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_B1: if (in_valid) begin
          last_q  <= in_last;
          data_q  <= {hi_q, in_byte};
          ctl_q   <= COPY_FLAG;
          state_q <= S_PRESENT;
          ready_q <= 1'b0;
          valid_q <= 1'b1;
        end
        S_PRESENT: if (!decompressor_busy) begin
          cnt_q   <= cnt_d;
          valid_q <= 1'b0;
          state_q <= S_GAP;
        end
        // idle cycle lets the decompressor raise busy before the next item appears
        S_GAP: if (last_q) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= (idx_q == LAST_IDX) ? S_CW : S_B0;
          idx_q   <= (idx_q == LAST_IDX) ? idx_q : idx_q + IW'(1);
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule
